// File: rtl/game_display_pkg.sv
// Shared types and constants for the subtraction-game display back end.
package game_disp_pkg;

  // Glyph codes: 0..9 are the decimal digits themselves.
  localparam logic [3:0] GLYPH_P     = 4'd10;
  localparam logic [3:0] GLYPH_DASH  = 4'd11;
  localparam logic [3:0] GLYPH_E     = 4'd12;
  localparam logic [3:0] GLYPH_BLANK = 4'd13;

  // Segment bus value with every segment (and dp) dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Anode bus value with every digit disabled.
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Largest pile that can be shown as two decimal digits.
  localparam logic [6:0] PILE_MAX = 7'd99;

  // Digit index; the value is also the anode bit it enables (DIG3 is leftmost).
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  // One frame's worth of game-core state.
  typedef struct packed {
    logic       win;
    logic       plr_turn;
    logic [6:0] pile;
    logic [2:0] max_sub;
    logic [2:0] max_add;
    logic       hide;
  } snap_t;

endpackage

// File: rtl/game_display_if.sv
// Game-core state in, segment/anode pins out.
interface game_display_if;

  logic       win;
  logic       plr_turn;
  logic [6:0] pile_size;
  logic [2:0] max_sub;
  logic [2:0] max_add;
  logic       hide;
  logic [7:0] seg;
  logic [3:0] an;

  // Game core side: drives state, may observe the display.
  modport master (
    output win, plr_turn, pile_size, max_sub, max_add, hide,
    input  seg, an
  );

  // Display side: consumes state, drives the pins.
  modport slave (
    input  win, plr_turn, pile_size, max_sub, max_add, hide,
    output seg, an
  );

endinterface

// File: rtl/game_display_seg7.sv
// Glyph code to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_decode
  import game_disp_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] segs
);

  // Lookup of the segment pattern for each glyph; unknown codes stay dark.
  always_comb begin
    segs = 7'b1111111;
    case (glyph)
      4'd0:        segs = 7'b1000000;
      4'd1:        segs = 7'b1111001;
      4'd2:        segs = 7'b0100100;
      4'd3:        segs = 7'b0110000;
      4'd4:        segs = 7'b0011001;
      4'd5:        segs = 7'b0010010;
      4'd6:        segs = 7'b0000010;
      4'd7:        segs = 7'b1111000;
      4'd8:        segs = 7'b0000000;
      4'd9:        segs = 7'b0010000;
      GLYPH_P:     segs = 7'b0001100;
      GLYPH_DASH:  segs = 7'b0111111;
      GLYPH_E:     segs = 7'b0000110;
      GLYPH_BLANK: segs = 7'b1111111;
      default:     segs = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/game_display.sv
// Four-digit multiplexed display of the game state with per-frame snapshot,
// hidden-move masking and a blinking winner banner.
module game_display
  import game_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 500,
  parameter int BLINK_DIV = 250000
) (
  input logic           clk_slow,
  input logic           btn_rst,
  game_display_if.slave bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt_r;
  digit_t             idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_on_r;
  logic               load_pending_r;
  snap_t              snap_r;
  logic [3:0]         an_r;
  logic [7:0]         seg_r;

  snap_t      snap_in_s;
  logic       scan_wrap_s;
  logic       frame_wrap_s;
  logic       load_s;
  logic       win_next_s;
  logic       blink_wrap_s;
  logic [3:0] tens_s;
  logic [3:0] ones_s;
  logic [3:0] glyph_s;
  logic       dp_s;
  logic [3:0] an_next_s;
  logic [6:0] segs_s;
  logic [7:0] seg_next_s;

  // Bundle the live inputs into one snapshot-shaped word.
  always_comb begin
    snap_in_s.win      = bus.win;
    snap_in_s.plr_turn = bus.plr_turn;
    snap_in_s.pile     = bus.pile_size;
    snap_in_s.max_sub  = bus.max_sub;
    snap_in_s.max_add  = bus.max_add;
    snap_in_s.hide     = bus.hide;
  end

  assign scan_wrap_s  = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
  assign frame_wrap_s = scan_wrap_s && (idx_r == DIG3) && !load_pending_r;
  assign load_s       = load_pending_r || frame_wrap_s;
  assign win_next_s   = load_s ? bus.win : snap_r.win;
  assign blink_wrap_s = (blink_cnt_r == BLINK_W'(BLINK_DIV - 1));

  // Marks the first cycle after reset release, when the snapshot is first taken.
  always_ff @(posedge clk_slow) begin
    if (btn_rst) begin
      load_pending_r <= 1'b1;
    end else begin
      load_pending_r <= 1'b0;
    end
  end

  // Scan counter and digit index; held in the load cycle so slot 0 gets its full width.
  always_ff @(posedge clk_slow) begin
    if (btn_rst || load_pending_r) begin
      scan_cnt_r <= '0;
      idx_r      <= DIG0;
    end else if (scan_wrap_s) begin
      scan_cnt_r <= '0;
      idx_r      <= digit_t'(idx_r + 2'd1);
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Snapshot of the game state, refreshed only at frame boundaries so nothing tears.
  always_ff @(posedge clk_slow) begin
    if (btn_rst) begin
      snap_r <= '0;
    end else if (load_s) begin
      snap_r <= snap_in_s;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Blink timer, driven by the post-load win flag; a fresh win always starts visible.
  always_ff @(posedge clk_slow) begin
    if (btn_rst || !win_next_s || !snap_r.win) begin
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else if (blink_wrap_s) begin
      blink_cnt_r <= '0;
      blink_on_r  <= ~blink_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  // Pile to tens/ones by comparing against each decade; the highest match wins.
  always_comb begin
    tens_s = 4'd0;
    ones_s = snap_r.pile[3:0];
    for (int t = 1; t <= 9; t++) begin
      if (snap_r.pile >= 7'(t * 10)) begin
        tens_s = 4'(t);
        ones_s = 4'(snap_r.pile - 7'(t * 10));
      end else begin
        // a lower decade was already recorded; nothing to change
      end
    end
  end

  // Mode mux: choose glyph, dp and anode pattern for the current digit slot.
  always_comb begin
    glyph_s   = GLYPH_BLANK;
    dp_s      = 1'b0;
    an_next_s = ~(4'b0001 << idx_r);
    if (snap_r.win) begin
      case (idx_r)
        DIG3:    glyph_s = GLYPH_P;
        DIG2:    glyph_s = snap_r.plr_turn ? 4'd2 : 4'd1;
        default: glyph_s = GLYPH_BLANK;
      endcase
      if (!blink_on_r) begin
        an_next_s = AN_OFF;
      end else begin
        an_next_s = ~(4'b0001 << idx_r);
      end
    end else begin
      case (idx_r)
        DIG3: begin
          glyph_s = {1'b0, snap_r.max_sub};
          dp_s    = !snap_r.plr_turn;
        end
        DIG2: glyph_s = {1'b0, snap_r.max_add};
        DIG1: begin
          if (snap_r.pile > PILE_MAX) begin
            glyph_s = GLYPH_E;
          end else if (snap_r.hide) begin
            glyph_s = GLYPH_DASH;
          end else begin
            glyph_s = tens_s;
          end
        end
        DIG0: begin
          dp_s = snap_r.plr_turn;
          if (snap_r.pile > PILE_MAX) begin
            glyph_s = GLYPH_E;
          end else if (snap_r.hide) begin
            glyph_s = GLYPH_DASH;
          end else begin
            glyph_s = ones_s;
          end
        end
        default: glyph_s = GLYPH_BLANK;
      endcase
    end
  end

  seg7_decode u_seg7 (
    .glyph (glyph_s),
    .segs  (segs_s)
  );

  // Append the active-low decimal point; a dark banner also blanks the segments.
  always_comb begin
    if (an_next_s == AN_OFF) begin
      seg_next_s = SEG_OFF;
    end else begin
      seg_next_s = {~dp_s, segs_s};
    end
  end

  // Output registers; dark during reset and during the snapshot load cycle.
  always_ff @(posedge clk_slow) begin
    if (btn_rst || load_pending_r) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;

endmodule

// File: doc/game_display.md
# game_display

Display back end for the subtraction game. It consumes the game core's state outputs (pile, limits, turn, hide, win) and drives a 4-digit, common-anode 7-segment display. Digits are time-multiplexed, and inputs are snapshotted once per scan frame so the display never tears. Hidden moves mask the pile, and a win is shown as a blinking winner banner. It sits between the game core and the board's segment/anode pins.

## Interface
- SCAN_DIV, 500: clk_slow cycles each digit stays enabled; must be ≥2.
- BLINK_DIV, 250000: clk_slow cycles per blink half-period in win mode; must be ≥2.
- clk_slow  in  1  the single clock.
- btn_rst  in  1  synchronous, active-high reset.
- win  in  1  game won; the winner is plr_turn.
- plr_turn  in  1  current player, 0 or 1.
- pile_size  in  7  current pile; legal range 0..99.
- max_sub  in  3  subtraction limit.
- max_add  in  3  addition limit.
- hide  in  1  last move was hidden.
- seg  out  8  active-low {dp,g,f,e,d,c,b,a}.
- an  out  4  active-low digit enables; an[3] is the leftmost digit.

## Operation
- **Snapshot registers** (win, plr_turn, pile_size, max_sub, max_add, hide):
  - Loaded on the first cycle after reset release.
  - Reloaded on every cycle where the digit index wraps 3→0.
  - All glyphs are derived only from the snapshot.
- **Scan:**
  - scan_cnt runs 0..SCAN_DIV-1.
  - On wrap, digit index advances 0→1→2→3→0.
  - Index d enables an[d] only.
- **Normal mode** (snap win=0):
  - an[3] = max_sub digit.
  - an[2] = max_add digit.
  - an[1] = pile tens, an[0] = pile ones.
  - Tens digit is shown even when 0 (pile 7 shows "07").
  - dp is lit on an[3] when plr_turn=0 and on an[0] when plr_turn=1; otherwise dp is off.
- **Hide:** snap hide=1 replaces an[1..0] with dash glyphs. Limits and dp are unaffected.
- **Out of range:** pile_size >99 shows "EE" on an[1..0]. This takes priority over hide.
- **Win mode** (snap win=1):
  - Digits read "P", winner number (plr_turn+1), blank, blank, on an[3..0].
  - No dp.
  - While blink_on=0, all of an[] is 1111.
- **Blink:**
  - blink_cnt counts 0..BLINK_DIV-1 and toggles blink_on on wrap, only while snap win=1.
  - When snap win=0, blink_cnt=0 and blink_on=1.
  - Each new win therefore starts visible.
- **BCD:** tens and ones come from pile_size by combinational compare/subtract against 90,80,…,10. No divider.

## Timing
- **Reset values** (cycle after btn_rst=1 is sampled):
  - an=1111, seg=8'hFF.
  - scan_cnt=0, index=0, blink_cnt=0, blink_on=1.
  - Snapshot = all zeros.
- **Reset mid-frame:** effective on the next edge with no partial digit, and it overrides every other event.
- **Output register:** an/seg are registered from index and snapshot with 1-cycle latency. The first enabled digit after reset is an[0] (an=1110), on the second edge after release.
- **Input latency:** an input change appears on the display no later than 4·SCAN_DIV+2 cycles after it, and never mid-frame.
- **Same-cycle events:** snapshot load and blink wrap on the same edge both take effect. Blink uses the new snap win.
- **Counter wrap:** all counters wrap with no gap cycle. Every digit is on for exactly SCAN_DIV cycles.

## Structure
- **Package game_disp_pkg:**
  - 4-bit glyph codes: 0–9, GLYPH_P, GLYPH_DASH, GLYPH_E, GLYPH_BLANK.
  - SEG_OFF = 8'hFF.
  - Digit index encoding.
- **Sub-module seg7_decode:** combinational glyph code → 7 active-low segments.
- **Top level:** counters, snapshot, BCD, mode mux and output registers live in game_display. dp is appended there.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=8.
- **Reset:** hold btn_rst 3 cycles with pile 63 → an=1111 and seg=FF during reset; 2 cycles after release an=1110 with seg="3"; then "6", max_add, max_sub follow at 4-cycle spacing.
- **Normal display:** pile=7, max_sub=4, max_add=2, plr_turn=1 → frame shows "4","2","0","7", with dp only on an[0].
- **Snapshot timing:** pile changes 45→40 mid-frame during an[1] → rest of the frame still shows "45"; "40" appears from the next an[0] slot.
- **Hide:** hide=1, pile=52 → an[1..0] show dashes while an[3..2] still show the limits; with pile=120, "EE" is shown instead.
- **Win:** win=1, plr_turn=0 → "P","1" visible for 8 cycles, then an=1111 for 8 cycles, repeating; dropping win restores normal mode with blink_on=1.
- **Mid-operation reset:** assert btn_rst during a win-blank phase → outputs match reset values next cycle and blink_on=1.
